// File: rtl/transpose_controller_if.sv
// Handshake and data bundle for transpose_controller.
// The abort signal exists only when TRANSPOSE_ABORT_EN is defined.
// master: the side that supplies rows and consumes columns.
// slave: the controller itself.
interface transpose_controller_if #(
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int WIDTH = 8
);
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic [COLS*WIDTH-1:0]   in_row;
  logic                    out_valid;
  logic                    out_ready;
  logic [ROWS*WIDTH-1:0]   out_col;
  logic                    out_last;
  logic                    busy;
  logic                    done;
`ifdef TRANSPOSE_ABORT_EN
  logic                    abort;

  modport master (
    output start, in_valid, in_row, out_ready, abort,
    input  in_ready, out_valid, out_col, out_last, busy, done
  );

  modport slave (
    input  start, in_valid, in_row, out_ready, abort,
    output in_ready, out_valid, out_col, out_last, busy, done
  );
`else
  modport master (
    output start, in_valid, in_row, out_ready,
    input  in_ready, out_valid, out_col, out_last, busy, done
  );

  modport slave (
    input  start, in_valid, in_row, out_ready,
    output in_ready, out_valid, out_col, out_last, busy, done
  );
`endif
endinterface

// File: rtl/transpose_controller.sv
// transpose_controller: loads a ROWS x COLS matrix one row per beat, then
// streams it back out one column per beat (the transpose).
// Optional feature macro: TRANSPOSE_ABORT_EN adds a synchronous abort input
// that returns the controller to IDLE without a done pulse.
module transpose_controller #(
  parameter int ROWS  = 3,
  parameter int COLS  = 4,
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst_n,
  transpose_controller_if.slave bus
);

  localparam int RW = $clog2(ROWS);
  localparam int CW = $clog2(COLS);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         row_cnt_q, row_cnt_d;
  logic [CW-1:0]         col_cnt_q, col_cnt_d;
  logic [ROWS*WIDTH-1:0] out_col_q, out_col_d;
  logic                  done_q, done_d;
  logic [WIDTH-1:0]      buf_q [ROWS][COLS];
  logic [WIDTH-1:0]      buf_d [ROWS][COLS];

  logic abort_w;
  logic in_hs;
  logic out_hs;
  logic load_col;

`ifdef TRANSPOSE_ABORT_EN
  assign abort_w = bus.abort;
`else
  assign abort_w = 1'b0;
`endif

  // Handshakes; abort wins over a same-cycle transfer on either side.
  assign in_hs  = (state_q == LOAD)  && bus.in_valid  && !abort_w;
  assign out_hs = (state_q == DRAIN) && bus.out_ready && !abort_w;

  // Outputs decoded straight from registered state, so they hold during stalls.
  assign bus.in_ready  = (state_q == LOAD);
  assign bus.out_valid = (state_q == DRAIN);
  assign bus.out_last  = (state_q == DRAIN) && (col_cnt_q == COL_LAST);
  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = done_q;
  assign bus.out_col   = out_col_q;

  // Next-state, counter, buffer-write and column-register logic.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one
    // unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    row_cnt_d = row_cnt_q;
    col_cnt_d = col_cnt_q;
    out_col_d = out_col_q;
    done_d    = 1'b0;
    buf_d     = buf_q;
    load_col  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d   = LOAD;
          row_cnt_d = '0;
        end
      end
      LOAD: begin
        if (in_hs) begin
          for (int c = 0; c < COLS; c++) begin
            buf_d[row_cnt_q][c] = bus.in_row[c*WIDTH +: WIDTH];
          end
          if (row_cnt_q == ROW_LAST) begin
            state_d   = DRAIN;
            col_cnt_d = '0;
            load_col  = 1'b1;
          end else begin
            row_cnt_d = row_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_hs) begin
          if (col_cnt_q == COL_LAST) begin
            state_d   = IDLE;
            col_cnt_d = '0;
            done_d    = 1'b1;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
            load_col  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Column 0 is read from buf_d so the row written this cycle is included.
    if (load_col) begin
      for (int r = 0; r < ROWS; r++) begin
        out_col_d[r*WIDTH +: WIDTH] = buf_d[r][col_cnt_d];
      end
    end

    if (abort_w) begin
      state_d   = IDLE;
      row_cnt_d = '0;
      col_cnt_d = '0;
      done_d    = 1'b0;
    end
  end

  // Control state, counters and output column register.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    if (!rst_n) begin
      state_q   <= IDLE;
      row_cnt_q <= '0;
      col_cnt_q <= '0;
      out_col_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_cnt_q <= row_cnt_d;
      col_cnt_q <= col_cnt_d;
      out_col_q <= out_col_d;
      done_q    <= done_d;
    end
  end

  // Matrix buffer storage.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is deliberately left without reset; every element is
    // rewritten before it is read, and the counters guard its validity.
    buf_q <= buf_d;
  end

endmodule

// File: tb/tb_transpose_controller.sv
// Directed self-checking bench for transpose_controller (3x4, 8-bit).
// Expected columns are hand-derived constants; abort steps run only when
// TRANSPOSE_ABORT_EN is defined.
module tb_transpose_controller;

  localparam int ROWS  = 3;
  localparam int COLS  = 4;
  localparam int WIDTH = 8;

  typedef logic [31:0] rows_t [3];
  typedef logic [23:0] cols_t [4];

  logic clk;
  logic rst_n;

  int n_tests = 0;
  int n_fail  = 0;

  // Matrix A: M[r][c] = 4r + c ; columns {8+c, 4+c, c} packed MSB-first.
  rows_t mat_a  = '{32'h03020100, 32'h07060504, 32'h0B0A0908};
  cols_t cols_a = '{24'h080400, 24'h090501, 24'h0A0602, 24'h0B0703};
  // Matrix B: M[r][c] = 0x10 + 4r + c.
  rows_t mat_b  = '{32'h13121110, 32'h17161514, 32'h1B1A1918};
  cols_t cols_b = '{24'h181410, 24'h191511, 24'h1A1612, 24'h1B1713};

  transpose_controller_if #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) bus ();

  transpose_controller #(.ROWS(ROWS), .COLS(COLS), .WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; sample/drive 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".in_ready"},  bus.in_ready,  1'b0);
    check({tag, ".out_valid"}, bus.out_valid, 1'b0);
    check({tag, ".out_last"},  bus.out_last,  1'b0);
    check({tag, ".busy"},      bus.busy,      1'b0);
    check({tag, ".done"},      bus.done,      1'b0);
  endtask

  task automatic begin_matrix(input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, ".load.in_ready"}, bus.in_ready, 1'b1);
    check({tag, ".load.busy"},     bus.busy,     1'b1);
  endtask

  // Feeds the three rows, with 'gap' idle cycles between rows.
  task automatic feed_rows(input string tag, input rows_t rows, input int gap,
                           input logic hold_start);
    for (int r = 0; r < ROWS; r++) begin
      check({tag, ".feed.in_ready"},  bus.in_ready,  1'b1);
      check({tag, ".feed.out_valid"}, bus.out_valid, 1'b0);
      bus.in_valid = 1'b1;
      bus.in_row   = rows[r];
      bus.start    = hold_start;
      tick();
      bus.in_valid = 1'b0;
      bus.in_row   = 32'hDEADBEEF;
      if (r < ROWS - 1) begin
        for (int g = 0; g < gap; g++) begin
          check({tag, ".gap.in_ready"},  bus.in_ready,  1'b1);
          check({tag, ".gap.out_valid"}, bus.out_valid, 1'b0);
          tick();
        end
      end
    end
  endtask

  // Drains four columns; bit i of pat is out_ready in drain cycle i.
  task automatic drain(input string tag, input cols_t exp, input logic [15:0] pat,
                       input logic hold_start);
    int idx;
    int cyc;
    idx = 0;
    cyc = 0;
    while (idx < COLS && cyc < 16) begin
      check({tag, ".out_valid"}, bus.out_valid, 1'b1);
      check({tag, ".out_col"},   bus.out_col,   exp[idx]);
      check({tag, ".out_last"},  bus.out_last,  (idx == COLS - 1));
      check({tag, ".in_ready"},  bus.in_ready,  1'b0);
      check({tag, ".done_early"}, bus.done,     1'b0);
      bus.out_ready = pat[cyc];
      bus.start     = hold_start;
      tick();
      if (pat[cyc]) idx++;
      cyc++;
    end
    bus.out_ready = 1'b0;
    check({tag, ".done"},       bus.done,      1'b1);
    check({tag, ".end.busy"},   bus.busy,      1'b0);
    check({tag, ".end.valid"},  bus.out_valid, 1'b0);
    check({tag, ".end.ready"},  bus.in_ready,  1'b0);
  endtask

  initial begin
    rst_n         = 1'b0;
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_row    = '0;
    bus.out_ready = 1'b0;
`ifdef TRANSPOSE_ABORT_EN
    bus.abort     = 1'b0;
`endif

    // Reset state.
    tick();
    tick();
    check_idle_outputs("reset");
    check("reset.out_col", bus.out_col, 24'h0);
    rst_n = 1'b1;
    tick();
    check_idle_outputs("idle_no_start");

    // Basic 3x4: done lands 8 cycles after start.
    begin_matrix("basic");
    feed_rows("basic", mat_a, 0, 1'b0);
    drain("basic", cols_a, 16'hFFFF, 1'b0);
    tick();
    check("basic.done_pulse_ends", bus.done, 1'b0);

    // Backpressure: out_ready pattern 1,0,0,1,0,0,1,0,0,1.
    begin_matrix("bp");
    feed_rows("bp", mat_b, 0, 1'b0);
    drain("bp", cols_b, 16'h0249, 1'b0);
    tick();

    // Input gaps of two cycles between rows.
    begin_matrix("gap");
    feed_rows("gap", mat_a, 2, 1'b0);
    drain("gap", cols_a, 16'hFFFF, 1'b0);
    tick();

    // Start held through LOAD and DRAIN, and past done.
    begin_matrix("sthold");
    feed_rows("sthold", mat_b, 0, 1'b1);
    drain("sthold", cols_b, 16'hFFFF, 1'b1);
    tick();
    bus.start = 1'b0;
    check("sthold.restart.in_ready", bus.in_ready, 1'b1);
    check("sthold.restart.done",     bus.done,     1'b0);
    feed_rows("sthold2", mat_a, 0, 1'b0);
    drain("sthold2", cols_a, 16'hFFFF, 1'b0);
    tick();

    // Reset in the middle of DRAIN, after column 1 is accepted.
    begin_matrix("rst");
    feed_rows("rst", mat_b, 0, 1'b0);
    bus.out_ready = 1'b1;
    check("rst.col0", bus.out_col, cols_b[0]);
    tick();
    check("rst.col1", bus.out_col, cols_b[1]);
    tick();
    bus.out_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst.async");
    check("rst.async.out_col", bus.out_col, 24'h0);
    rst_n = 1'b1;
    tick();
    check_idle_outputs("rst.after");
    begin_matrix("rst_new");
    feed_rows("rst_new", mat_a, 0, 1'b0);
    drain("rst_new", cols_a, 16'hFFFF, 1'b0);
    tick();

`ifdef TRANSPOSE_ABORT_EN
    // Abort after two rows, with a row handshake offered in the same cycle.
    begin_matrix("abort");
    bus.in_valid = 1'b1;
    bus.in_row   = mat_b[0];
    tick();
    bus.in_row   = mat_b[1];
    tick();
    bus.in_row   = mat_b[2];
    bus.abort    = 1'b1;
    tick();
    bus.abort    = 1'b0;
    bus.in_valid = 1'b0;
    check_idle_outputs("abort.next");
    tick();
    check_idle_outputs("abort.after");
    begin_matrix("abort_new");
    feed_rows("abort_new", mat_b, 0, 1'b0);
    drain("abort_new", cols_b, 16'hFFFF, 1'b0);
    tick();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
